// File: rtl/alu_muldiv_ctrl_if.sv
// Execute-stage bundle between the pipeline and the ALU control / mul-div sequencer.
// Latency: n/a (signal bundle only).
// Backpressure: stall/busy travel slave->master; the master holds its instruction while stall is high.
interface alu_muldiv_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             valid;
    logic [5:0]       opcode;
    logic [5:0]       rtype_fncode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [5:0]       fncode;
    logic             stall;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    // Pipeline side: presents the instruction, observes decode and HI/LO state
    modport master (
        output valid, opcode, rtype_fncode, a, b,
        input  fncode, stall, busy, hi, lo
    );

    // Execute block side
    modport slave (
        input  valid, opcode, rtype_fncode, a, b,
        output fncode, stall, busy, hi, lo
    );
endinterface

// File: rtl/alu_muldiv_ctrl.sv
// ALU function decode plus iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO pair.
// Latency: fncode/stall combinational; MTHI/MTLO one edge; mul/div WIDTH+1 busy cycles.
// Backpressure: HI/LO-class instructions stall while busy; all other instructions never stall.
module alu_muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    alu_muldiv_ctrl_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN
    } state_t;

    state_t             state_q, state_d;
    logic               busy_q, busy_d;
    logic [CW-1:0]      count_q, count_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   op_b_q, op_b_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               div_zero_q, div_zero_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic [5:0]         fncode_c;
    logic               hilo_cls;
    logic               accept;

    // ALU function code from the opcode; immediates and memory ops map onto their R-type twins
    always_comb begin
        fncode_c = 6'h3F;
        case (bus.opcode)
            6'h09, 6'h20, 6'h21, 6'h23, 6'h24,
            6'h25, 6'h28, 6'h29, 6'h2B: fncode_c = 6'h21;
            6'h0C:                      fncode_c = 6'h24;
            6'h0D:                      fncode_c = 6'h25;
            6'h0E:                      fncode_c = 6'h26;
            6'h0A:                      fncode_c = 6'h2A;
            6'h0B:                      fncode_c = 6'h2B;
            6'h04, 6'h05:               fncode_c = 6'h23;
            6'h00:                      fncode_c = bus.rtype_fncode;
            default:                    fncode_c = 6'h3F;
        endcase
    end

    // Identify instructions that touch HI/LO or the sequencer
    always_comb begin
        hilo_cls = 1'b0;
        if (bus.opcode == 6'h00) begin
            case (bus.rtype_fncode)
                FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO,
                FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: hilo_cls = 1'b1;
                default:                            hilo_cls = 1'b0;
            endcase
        end
    end

    assign accept     = bus.valid & hilo_cls & ~busy_q;
    assign bus.stall  = bus.valid & hilo_cls & busy_q;
    assign bus.fncode = fncode_c;
    assign bus.busy   = busy_q;
    assign bus.hi     = hi_q;
    assign bus.lo     = lo_q;

    // Operand preparation at acceptance: magnitudes for signed ops, raw values otherwise
    logic             in_signed;
    logic             in_div;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    assign in_signed = (bus.rtype_fncode == FN_MULT) || (bus.rtype_fncode == FN_DIV);
    assign in_div    = (bus.rtype_fncode == FN_DIV)  || (bus.rtype_fncode == FN_DIVU);
    assign a_mag     = (in_signed && bus.a[WIDTH-1]) ? ('0 - bus.a) : bus.a;
    assign b_mag     = (in_signed && bus.b[WIDTH-1]) ? ('0 - bus.b) : bus.b;

    // Multiply step: add the multiplicand when the current low bit is set, then shift right
    logic [WIDTH:0] mul_sum;
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, op_b_q} : '0);

    // Divide step: restoring; remainder lives in the upper half, quotient bits shift into the lower
    logic [WIDTH:0]   div_shift;
    logic             div_ok;
    logic [WIDTH-1:0] div_diff;
    assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_ok    = (div_shift >= {1'b0, op_b_q});
    assign div_diff  = div_shift[WIDTH-1:0] - op_b_q;

    logic [2*WIDTH-1:0] step_acc;
    assign step_acc = is_div_q
        ? {(div_ok ? div_diff : div_shift[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ok}
        : {mul_sum, acc_q[WIDTH-1:1]};

    // Sign correction applied in FIN; divide-by-zero forces an all-ones quotient
    logic [2*WIDTH-1:0] prod_fin;
    logic [WIDTH-1:0]   quo_neg;
    logic [WIDTH-1:0]   quo_fin;
    logic [WIDTH-1:0]   rem_fin;
    assign prod_fin = neg_res_q ? ('0 - acc_q) : acc_q;
    assign quo_neg  = '0 - acc_q[WIDTH-1:0];
    assign quo_fin  = div_zero_q ? '1 : (neg_res_q ? quo_neg : acc_q[WIDTH-1:0]);
    assign rem_fin  = neg_rem_q ? ('0 - acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];

    // Sequencer next-state: accept in IDLE, iterate WIDTH times in RUN, commit HI/LO out of FIN
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        acc_d      = acc_q;
        op_b_d     = op_b_q;
        is_div_d   = is_div_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (bus.rtype_fncode)
                        FN_MTHI: hi_d = bus.a;
                        FN_MTLO: lo_d = bus.a;
                        FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                            state_d    = S_RUN;
                            count_d    = '0;
                            acc_d      = {{WIDTH{1'b0}}, a_mag};
                            op_b_d     = b_mag;
                            is_div_d   = in_div;
                            neg_res_d  = in_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                            neg_rem_d  = in_signed & in_div & bus.a[WIDTH-1];
                            div_zero_d = in_div & (bus.b == '0);
                        end
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                acc_d   = step_acc;
                count_d = count_q + CW'(1);
                if (count_q == CW'(WIDTH - 1)) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                if (is_div_q) begin
                    hi_d = rem_fin;
                    lo_d = quo_fin;
                end else begin
                    hi_d = prod_fin[2*WIDTH-1:WIDTH];
                    lo_d = prod_fin[WIDTH-1:0];
                end
                count_d = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State registers; reset wins over a same-edge acceptance and clears HI/LO
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            count_q    <= '0;
            acc_q      <= '0;
            op_b_q     <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            count_q    <= count_d;
            acc_q      <= acc_d;
            op_b_q     <= op_b_d;
            is_div_q   <= is_div_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end
endmodule

// File: tb/tb_alu_muldiv_ctrl.sv
// Bench for alu_muldiv_ctrl: decode table, directed and random mul/div against an arithmetic model,
// stall handshake, back-to-back issue, HI/LO moves and reset behaviour.
module tb_alu_muldiv_ctrl;
    localparam int W = 32;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADDU  = 6'h21;

    logic clk = 1'b0;
    logic reset;
    int   tests_run    = 0;
    int   tests_failed = 0;

    alu_muldiv_ctrl_if #(.WIDTH(W)) bus ();

    alu_muldiv_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [5:0] dec_op  [18] = '{6'h09, 6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B,
                                 6'h0C, 6'h0D, 6'h0E, 6'h0A, 6'h0B, 6'h04, 6'h05, 6'h02, 6'h3F};
    logic [5:0] dec_exp [18] = '{6'h21, 6'h21, 6'h21, 6'h21, 6'h21, 6'h21, 6'h21, 6'h21, 6'h21,
                                 6'h24, 6'h25, 6'h26, 6'h2A, 6'h2B, 6'h23, 6'h23, 6'h3F, 6'h3F};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [5:0] f, input logic [W-1:0] a_i, input logic [W-1:0] b_i);
        bus.valid        = 1'b1;
        bus.opcode       = 6'h00;
        bus.rtype_fncode = f;
        bus.a            = a_i;
        bus.b            = b_i;
    endtask

    // Reference results from plain 64-bit arithmetic (division truncates toward zero)
    task automatic model(input logic [5:0] f, input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                         output logic [W-1:0] h, output logic [W-1:0] l);
        longint      sa, sb, sp;
        logic [63:0] up;
        sa = longint'($signed(a_i));
        sb = longint'($signed(b_i));
        h  = '0;
        l  = '0;
        if (f == F_MULT) begin
            sp = sa * sb;
            up = sp;
            h  = up[63:32];
            l  = up[31:0];
        end else if (f == F_MULTU) begin
            up = {32'b0, a_i} * {32'b0, b_i};
            h  = up[63:32];
            l  = up[31:0];
        end else if (b_i == '0) begin
            h = a_i;
            l = '1;
        end else if (f == F_DIV) begin
            l = 32'(sa / sb);
            h = 32'(sa % sb);
        end else begin
            l = a_i / b_i;
            h = a_i % b_i;
        end
    endtask

    task automatic run_op(input logic [5:0] f, input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                          input logic [W-1:0] exp_h, input logic [W-1:0] exp_l, input string nm);
        int cnt;
        present(f, a_i, b_i);
        tick();
        bus.valid = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        cnt = 0;
        while (bus.busy && cnt < 200) begin
            cnt++;
            tick();
        end
        tests_run++;
        if (cnt !== W + 1) begin
            tests_failed++;
            $display("FAIL %s busy_cycles got=%0d exp=%0d", nm, cnt, W + 1);
        end
        tests_run++;
        if (bus.hi !== exp_h || bus.lo !== exp_l) begin
            tests_failed++;
            $display("FAIL %s hi/lo got=%h/%h exp=%h/%h a=%h b=%h", nm, bus.hi, bus.lo, exp_h, exp_l, a_i, b_i);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        bus.valid = 1'b0;
        bus.opcode = '0;
        bus.rtype_fncode = '0;
        bus.a = '0;
        bus.b = '0;
        tick();
        tick();
        tests_run++;
        if (bus.busy !== 1'b0 || bus.hi !== '0 || bus.lo !== '0) begin
            tests_failed++;
            $display("FAIL reset_state busy=%b hi=%h lo=%h exp 0/0/0", bus.busy, bus.hi, bus.lo);
        end
        present(F_MFHI, '0, '0);
        #1;
        tests_run++;
        if (bus.stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_stall got=%b exp=0", bus.stall);
        end
        bus.valid = 1'b0;
        reset     = 1'b0;
        tick();
    endtask

    task automatic test_decode();
        bus.valid = 1'b0;
        for (int i = 0; i < 18; i++) begin
            bus.opcode       = dec_op[i];
            bus.rtype_fncode = 6'($urandom);
            #1;
            tests_run++;
            if (bus.fncode !== dec_exp[i]) begin
                tests_failed++;
                $display("FAIL decode op=%h got=%h exp=%h", dec_op[i], bus.fncode, dec_exp[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            logic [5:0] fn;
            fn = (i == 0) ? 6'h2A : 6'($urandom);
            bus.opcode       = 6'h00;
            bus.rtype_fncode = fn;
            #1;
            tests_run++;
            if (bus.fncode !== fn) begin
                tests_failed++;
                $display("FAIL decode_rtype funct=%h got=%h", fn, bus.fncode);
            end
        end
        tick();
    endtask

    task automatic test_muldiv_directed();
        run_op(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max");
        run_op(F_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, "mult_neg3x5");
        run_op(F_MULT,  32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF2, "mult_7xneg2");
        run_op(F_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg7by2");
        run_op(F_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div_7byneg2");
        run_op(F_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, "divu_by0");
        run_op(F_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, "div_neg_by0");
        run_op(F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_minneg");
    endtask

    task automatic test_muldiv_random();
        logic [5:0]   f;
        logic [W-1:0] ra, rb, eh, el;
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0:       f = F_MULT;
                1:       f = F_MULTU;
                2:       f = F_DIV;
                default: f = F_DIVU;
            endcase
            ra = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 7))
                0:       rb = '0;
                1:       rb = 32'hFFFFFFFF;
                2:       rb = 32'($urandom_range(1, 9));
                default: rb = $urandom;
            endcase
            model(f, ra, rb, eh, el);
            run_op(f, ra, rb, eh, el, "random");
        end
    endtask

    task automatic test_stall();
        int cnt;
        present(F_DIVU, 32'd100, 32'd7);
        tick();
        present(F_MFLO, $urandom, $urandom);
        #1;
        cnt = 0;
        while (bus.stall && cnt < 200) begin
            cnt++;
            if (cnt == 10) begin
                bus.rtype_fncode = F_ADDU;
                #1;
                tests_run++;
                if (bus.stall !== 1'b0 || bus.fncode !== F_ADDU) begin
                    tests_failed++;
                    $display("FAIL addu_while_busy stall=%b fncode=%h exp 0/%h", bus.stall, bus.fncode, F_ADDU);
                end
                bus.rtype_fncode = F_MFLO;
                #1;
            end
            if (cnt == 20) begin
                bus.valid = 1'b0;
                #1;
                tests_run++;
                if (bus.stall !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL invalid_no_stall got=%b exp=0", bus.stall);
                end
                bus.valid = 1'b1;
                #1;
            end
            tick();
            #1;
        end
        tests_run++;
        if (cnt !== W + 1) begin
            tests_failed++;
            $display("FAIL stall_cycles got=%0d exp=%0d", cnt, W + 1);
        end
        tests_run++;
        if (bus.lo !== 32'd14 || bus.hi !== 32'd2) begin
            tests_failed++;
            $display("FAIL divu_100_7 hi/lo got=%0d/%0d exp=2/14", bus.hi, bus.lo);
        end
        tick();
        bus.valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        int cnt;
        present(F_MULTU, 32'd3, 32'd4);
        tick();
        present(F_MTHI, 32'h0000ABCD, $urandom);
        #1;
        cnt = 0;
        while (bus.stall && cnt < 200) begin
            cnt++;
            tick();
        end
        tests_run++;
        if (cnt !== W + 1 || bus.hi !== '0 || bus.lo !== 32'd12) begin
            tests_failed++;
            $display("FAIL b2b_hold cycles=%0d hi=%h lo=%h exp %0d/0/c", cnt, bus.hi, bus.lo, W + 1);
        end
        tick();
        bus.valid = 1'b0;
        tests_run++;
        if (bus.hi !== 32'h0000ABCD || bus.lo !== 32'd12 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_mthi hi=%h lo=%h busy=%b exp abcd/c/0", bus.hi, bus.lo, bus.busy);
        end
    endtask

    task automatic test_hilo_moves();
        logic [W-1:0] hv, lv;
        hv = $urandom;
        lv = $urandom;
        present(F_MTLO, lv, $urandom);
        tick();
        present(F_MTHI, hv, $urandom);
        tick();
        tests_run++;
        if (bus.hi !== hv || bus.lo !== lv) begin
            tests_failed++;
            $display("FAIL mthi_mtlo got=%h/%h exp=%h/%h", bus.hi, bus.lo, hv, lv);
        end
        present(F_MFHI, ~hv, ~lv);
        tick();
        present(F_MFLO, ~hv, ~lv);
        tick();
        bus.valid        = 1'b0;
        bus.rtype_fncode = F_MTHI;
        tick();
        tests_run++;
        if (bus.hi !== hv || bus.lo !== lv || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL mf_and_invalid hi=%h lo=%h busy=%b exp %h/%h/0", bus.hi, bus.lo, bus.busy, hv, lv);
        end
    endtask

    task automatic test_reset_mid();
        present(F_MULT, $urandom | 32'h1, $urandom | 32'h1);
        tick();
        bus.valid = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests_run++;
        if (bus.busy !== 1'b0 || bus.hi !== '0 || bus.lo !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid busy=%b hi=%h lo=%h exp 0/0/0", bus.busy, bus.hi, bus.lo);
        end
        present(F_MTHI, 32'h00001234, '0);
        tick();
        bus.valid = 1'b0;
        tests_run++;
        if (bus.hi !== 32'h00001234) begin
            tests_failed++;
            $display("FAIL mthi_after_reset got=%h exp=00001234", bus.hi);
        end
        present(F_MULT, 32'd9, 32'd9);
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        bus.valid = 1'b0;
        tick();
        tests_run++;
        if (bus.busy !== 1'b0 || bus.hi !== '0) begin
            tests_failed++;
            $display("FAIL reset_priority busy=%b hi=%h exp 0/0", bus.busy, bus.hi);
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_muldiv_directed();
        test_muldiv_random();
        test_stall();
        test_back_to_back();
        test_hilo_moves();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/alu_muldiv_ctrl.md
# alu_muldiv_ctrl

Execute-stage ALU control with an integrated iterative multiply/divide sequencer and HI/LO register pair for the MIPS CPU. The block decodes `opcode`/`rtype_fncode` into the 6-bit ALU function code, covering the full load/store/immediate set. It also runs MULT/MULTU/DIV/DIVU as a multi-cycle operation with a busy/stall handshake toward the pipeline control, and serves MFHI/MFLO/MTHI/MTLO. The operand width is parametrised.

## Interface
- `WIDTH`, default 32: operand width in bits; HI and LO are each WIDTH bits.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `valid` in 1: the instruction currently in execute is real (not a bubble).
- `opcode` in 6: instruction bits [31:26].
- `rtype_fncode` in 6: instruction bits [5:0].
- `a` in WIDTH: rs operand.
- `b` in WIDTH: rt operand.
- `fncode` out 6: combinational ALU function code.
- `stall` out 1: combinational; the current HI/LO-class instruction cannot be accepted this cycle.
- `busy` out 1: registered; a mul/div is in progress.
- `hi` out WIDTH: registered HI.
- `lo` out WIDTH: registered LO.

## Operation
- **fncode decode (combinational)**
  - ADDIU(09), LB(20), LH(21), LW(23), LBU(24), LHU(25), SB(28), SH(29), SW(2B) → ADDU(21).
  - ANDI(0C) → AND(24); ORI(0D) → OR(25); XORI(0E) → XOR(26).
  - SLTI(0A) → SLT(2A); SLTIU(0B) → SLTU(2B); BEQ(04), BNE(05) → SUBU(23).
  - RTYPE(00) → `rtype_fncode`; any other opcode → 6'h3F.
- **HI/LO class**
  - Condition: opcode = 00 and funct ∈ {MFHI 10, MTHI 11, MFLO 12, MTLO 13, MULT 18, MULTU 19, DIV 1A, DIVU 1B}.
- **stall**
  - stall = `valid` & HI/LO class & `busy`.
  - The pipeline holds the instruction; the block ignores it while stall = 1.
- **Acceptance**
  - An instruction is accepted when `valid` & HI/LO class & !`busy`.
  - MTHI: `hi` ← `a` at the next edge. MTLO: `lo` ← `a` at the next edge.
  - MFHI/MFLO: no state change; the datapath reads `hi`/`lo` directly.
  - MULT/MULTU/DIV/DIVU: operands are latched and the FSM starts.
- **FSM states: IDLE, RUN, FIN.**
  - IDLE → RUN on mul/div acceptance.
    - Latch |a| and |b| (signed ops) or raw a and b (unsigned ops).
    - Latch the result sign flags; clear the count.
  - RUN: one iteration per cycle; count 0..WIDTH-1; RUN → FIN when count = WIDTH-1.
    - Multiply: shift-add into a 2·WIDTH accumulator.
    - Divide: restoring shift-subtract producing quotient and remainder.
  - FIN: apply sign correction (two's-complement negate), then load `hi`/`lo`; FIN → IDLE.
- **Multiply result**
  - {hi, lo} = full 2·WIDTH product.
  - Signed product is negated when sign(a) ≠ sign(b).
- **Divide result**
  - lo = quotient, truncated toward zero. hi = remainder, carrying the sign of the dividend.
  - Divide by zero: hi = `a`, lo = all-ones, for both DIV and DIVU; latency unchanged.
  - DIV of most-negative by −1: lo = most-negative (e.g. 0x80000000), hi = 0.
- **Arithmetic**
  - All magnitudes and the accumulator are unsigned internally.
  - The count register is $clog2(WIDTH)+1 bits wide.

## Timing
- **Reset**
  - State = IDLE; `busy` = 0; `hi` = 0; `lo` = 0; count = 0.
  - `stall` = 0 as a consequence of `busy` = 0.
- **Mul/div latency:** accepted at edge E0.
  - `busy` = 1 from after E0 through the edge E(WIDTH+1).
  - `hi`/`lo` updated at E(WIDTH+1), with `busy` = 0 in the same cycle.
  - Total: WIDTH+1 busy cycles (33 for WIDTH=32).
- **Back-to-back issue**
  - A HI/LO-class instruction presented during the FIN cycle is stalled.
  - It is accepted in the next cycle, which sees the new `hi`/`lo`.
- **Unaffected instructions**
  - Non-HI/LO instructions never stall, even while busy.
  - `fncode` is valid in the same cycle for every instruction.
- **`valid` = 0:** nothing is accepted and `stall` = 0.
- **Reset mid-operation:** the operation is discarded and `hi`/`lo` are cleared; the next cycle is IDLE.
- **Reset priority:** reset at the same edge as an acceptance wins; nothing is latched.

## Test plan
- Decode sweep: each listed opcode → the required fncode; opcode 00 with funct 2A → 2A; opcode 02 → 3F.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF.
  - busy is high for 33 cycles.
  - Then hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=0xFFFFFFFD (−3), b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU a=7, b=0 → hi=7, lo=0xFFFFFFFF.
- Stall handshake:
  - DIVU 100/7 issued, then MFLO held valid: stall=1 for exactly 33 cycles.
  - When stall drops, lo=14 and hi=2.
  - An ADDU issued mid-operation does not stall.
- Reset 10 cycles into a MULT: next cycle busy=0, hi=lo=0.
  - A subsequent MTHI a=0x1234 → hi=0x1234 one edge later.
